// File: rtl/demux1x4_stream_if.sv
// Stream bundle for the 1-to-4 demultiplexer: one upstream word channel,
// four downstream channels and the per-channel debug counters.
interface demux1x4_stream_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic                  valid_i;
    logic                  ready_o;
    logic [DATA_W-1:0]     data_i;
    logic [1:0]            sel_i;
    logic [3:0]            valid_o;
    logic [4*DATA_W-1:0]   data_o;
    logic [3:0]            ready_i;
    logic [4*CNT_W-1:0]    cnt_o;
    logic                  clr_cnt_i;

    modport slave (
        input  valid_i, data_i, sel_i, ready_i, clr_cnt_i,
        output ready_o, valid_o, data_o, cnt_o
    );

    modport master (
        output valid_i, data_i, sel_i, ready_i, clr_cnt_i,
        input  ready_o, valid_o, data_o, cnt_o
    );
endinterface

// File: rtl/demux1x4_stream.sv
// Registered 1-to-4 valid/ready demultiplexer. Each output channel owns a
// one-entry register, so a stall on one channel never blocks the others.
module demux1x4_stream #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    demux1x4_stream_if.slave bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_e;

    chan_state_e       state_q [4];
    chan_state_e       state_d [4];
    logic [DATA_W-1:0] data_q  [4];
    logic [DATA_W-1:0] data_d  [4];
    logic [CNT_W-1:0]  cnt_q   [4];
    logic [CNT_W-1:0]  cnt_d   [4];
    logic [3:0]        push;
    logic [3:0]        pop;
    logic              up_ready;

    // Upstream ready only looks at the selected channel; valid_i is kept out
    // of this path so the handshake cannot form a valid->ready loop.
    always_comb begin
        up_ready = (state_q[bus.sel_i] == EMPTY) || bus.ready_i[bus.sel_i];
        for (int k = 0; k < 4; k++) begin
            push[k] = bus.valid_i && up_ready && (bus.sel_i == 2'(k));
            pop[k]  = (state_q[k] == FULL) && bus.ready_i[k];
        end
    end

    // Per-channel EMPTY/FULL machine; a push overrides a pop so a channel
    // with a ready consumer sustains one word per cycle with no bubble.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            state_d[k] = state_q[k];
            data_d[k]  = data_q[k];
            cnt_d[k]   = cnt_q[k];

            unique case (state_q[k])
                EMPTY: begin
                    if (push[k]) begin
                        state_d[k] = FULL;
                        data_d[k]  = bus.data_i;
                    end
                end
                FULL: begin
                    if (push[k]) begin
                        data_d[k] = bus.data_i;
                    end else if (pop[k]) begin
                        state_d[k] = EMPTY;
                    end
                end
                default: state_d[k] = EMPTY;
            endcase

            if (bus.clr_cnt_i) begin
                cnt_d[k] = '0;
            end else if (push[k]) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= EMPTY;
                data_q[k]  <= '0;
                cnt_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= state_d[k];
                data_q[k]  <= data_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
        end
    end

    always_comb begin
        bus.ready_o = up_ready;
        bus.valid_o = '0;
        bus.data_o  = '0;
        bus.cnt_o   = '0;
        for (int k = 0; k < 4; k++) begin
            bus.valid_o[k]                   = (state_q[k] == FULL);
            bus.data_o[k*DATA_W +: DATA_W]   = data_q[k];
            bus.cnt_o[k*CNT_W +: CNT_W]      = cnt_q[k];
        end
    end

endmodule

// File: tb/tb_demux1x4_stream.sv
// Directed and random checks for demux1x4_stream; a second instance with
// 4-bit counters shares the same stimulus to exercise counter wrap.
module tb_demux1x4_stream;

    logic clk;
    logic rst_n;

    int vectors;
    int miscompares;

    demux1x4_stream_if #(.DATA_W(8), .CNT_W(16)) bus ();
    demux1x4_stream_if #(.DATA_W(8), .CNT_W(4))  bus4 ();

    demux1x4_stream #(.DATA_W(8), .CNT_W(16)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    demux1x4_stream #(.DATA_W(8), .CNT_W(4)) dut_w4 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus4.slave)
    );

    assign bus4.valid_i   = bus.valid_i;
    assign bus4.data_i    = bus.data_i;
    assign bus4.sel_i     = bus.sel_i;
    assign bus4.ready_i   = bus.ready_i;
    assign bus4.clr_cnt_i = bus.clr_cnt_i;

    logic [7:0]  dout [4];
    logic [15:0] cnt  [4];
    logic [3:0]  cnt4_3;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            dout[k] = bus.data_o[k*8 +: 8];
            cnt[k]  = bus.cnt_o[k*16 +: 16];
        end
        cnt4_3 = bus4.cnt_o[15:12];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_counters();
        bus.valid_i   = 1'b0;
        bus.clr_cnt_i = 1'b1;
        tick();
        bus.clr_cnt_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.valid_i   = 1'b0;
        bus.data_i    = '0;
        bus.sel_i     = '0;
        bus.ready_i   = '0;
        bus.clr_cnt_i = 1'b0;
        #1;
        vectors++;
        if (bus.valid_o !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_valid: got %b expected 0000", bus.valid_o);
        end
        vectors++;
        if (bus.data_o !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: got %h expected 0", bus.data_o);
        end
        vectors++;
        if (bus.cnt_o !== 64'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_cnt: got %h expected 0", bus.cnt_o);
        end
        vectors++;
        if (bus.ready_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_ready: got %b expected 1", bus.ready_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_routing();
        bus.ready_i = 4'hF;
        for (int i = 0; i < 4; i++) begin
            bus.valid_i = 1'b1;
            bus.sel_i   = 2'(i);
            bus.data_i  = 8'hA0 + 8'(i);
            #1;
            vectors++;
            if (bus.ready_o !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL route_ready ch%0d: got %b expected 1", i, bus.ready_o);
            end
            tick();
            vectors++;
            if (bus.valid_o !== 4'(1 << i)) begin
                miscompares++;
                $display("[TB] FAIL route_valid ch%0d: got %b expected %b", i, bus.valid_o, 4'(1 << i));
            end
            vectors++;
            if (dout[i] !== 8'hA0 + 8'(i)) begin
                miscompares++;
                $display("[TB] FAIL route_data ch%0d: got %h expected %h", i, dout[i], 8'hA0 + 8'(i));
            end
        end
        bus.valid_i = 1'b0;
        tick();
        vectors++;
        if (bus.valid_o !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL route_drain: got %b expected 0000", bus.valid_o);
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (cnt[k] !== 16'd1) begin
                miscompares++;
                $display("[TB] FAIL route_cnt ch%0d: got %0d expected 1", k, cnt[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_counters();
        bus.ready_i = 4'b1011;
        // 0x55 lands on stalled channel 2
        bus.valid_i = 1'b1; bus.sel_i = 2'd2; bus.data_i = 8'h55;
        #1;
        vectors++;
        if (bus.ready_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_first_ready: got %b expected 1", bus.ready_o);
        end
        tick();
        vectors++;
        if (bus.valid_o[2] !== 1'b1 || dout[2] !== 8'h55) begin
            miscompares++;
            $display("[TB] FAIL bp_hold55: got v=%b d=%h expected v=1 d=55", bus.valid_o[2], dout[2]);
        end
        // 0x66 must be refused while channel 2 is stalled
        bus.data_i = 8'h66;
        #1;
        vectors++;
        if (bus.ready_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_stall_ready: got %b expected 0", bus.ready_o);
        end
        tick();
        vectors++;
        if (bus.valid_o[2] !== 1'b1 || dout[2] !== 8'h55) begin
            miscompares++;
            $display("[TB] FAIL bp_still55: got v=%b d=%h expected v=1 d=55", bus.valid_o[2], dout[2]);
        end
        // channel 0 keeps flowing while channel 2 is stalled
        bus.sel_i = 2'd0; bus.data_i = 8'h70;
        #1;
        vectors++;
        if (bus.ready_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_iso_ready: got %b expected 1", bus.ready_o);
        end
        tick();
        vectors++;
        if (bus.valid_o !== 4'b0101 || dout[0] !== 8'h70 || dout[2] !== 8'h55) begin
            miscompares++;
            $display("[TB] FAIL bp_iso_data: got v=%b d0=%h d2=%h expected v=0101 d0=70 d2=55",
                     bus.valid_o, dout[0], dout[2]);
        end
        // release the stall while 0x66 is pending
        bus.sel_i = 2'd2; bus.data_i = 8'h66;
        #1;
        vectors++;
        if (bus.ready_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_pending_ready: got %b expected 0", bus.ready_o);
        end
        bus.ready_i = 4'hF;
        #1;
        vectors++;
        if (bus.ready_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_release_ready: got %b expected 1", bus.ready_o);
        end
        tick();
        vectors++;
        if (bus.valid_o !== 4'b0100 || dout[2] !== 8'h66) begin
            miscompares++;
            $display("[TB] FAIL bp_load66: got v=%b d2=%h expected v=0100 d2=66", bus.valid_o, dout[2]);
        end
        bus.sel_i = 2'd0; bus.data_i = 8'h77;
        #1;
        vectors++;
        if (bus.ready_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_77_ready: got %b expected 1", bus.ready_o);
        end
        tick();
        vectors++;
        if (bus.valid_o !== 4'b0001 || dout[0] !== 8'h77) begin
            miscompares++;
            $display("[TB] FAIL bp_deliver77: got v=%b d0=%h expected v=0001 d0=77", bus.valid_o, dout[0]);
        end
        bus.valid_i = 1'b0;
        tick();
        vectors++;
        if (bus.valid_o !== 4'b0000 || cnt[0] !== 16'd2 || cnt[2] !== 16'd2) begin
            miscompares++;
            $display("[TB] FAIL bp_counts: got v=%b c0=%0d c2=%0d expected v=0000 c0=2 c2=2",
                     bus.valid_o, cnt[0], cnt[2]);
        end
    endtask

    task automatic test_back_to_back();
        clear_counters();
        bus.ready_i = 4'hF;
        for (int i = 0; i < 16; i++) begin
            bus.valid_i = 1'b1; bus.sel_i = 2'd1; bus.data_i = 8'h10 + 8'(i);
            #1;
            vectors++;
            if (bus.ready_o !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL b2b_ready word%0d: got %b expected 1", i, bus.ready_o);
            end
            tick();
            vectors++;
            if (bus.valid_o !== 4'b0010 || dout[1] !== 8'h10 + 8'(i)) begin
                miscompares++;
                $display("[TB] FAIL b2b_data word%0d: got v=%b d1=%h expected v=0010 d1=%h",
                         i, bus.valid_o, dout[1], 8'h10 + 8'(i));
            end
        end
        bus.valid_i = 1'b0;
        tick();
        vectors++;
        if (cnt[1] !== 16'd16 || bus.valid_o !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL b2b_cnt: got c1=%0d v=%b expected c1=16 v=0000", cnt[1], bus.valid_o);
        end
    endtask

    task automatic test_wrap_clear();
        clear_counters();
        bus.ready_i = 4'hF;
        for (int i = 0; i < 17; i++) begin
            bus.valid_i = 1'b1; bus.sel_i = 2'd3; bus.data_i = 8'h30 + 8'(i);
            tick();
        end
        bus.valid_i = 1'b0;
        vectors++;
        if (cnt4_3 !== 4'd1) begin
            miscompares++;
            $display("[TB] FAIL wrap_cnt4: got %0d expected 1", cnt4_3);
        end
        vectors++;
        if (cnt[3] !== 16'd17) begin
            miscompares++;
            $display("[TB] FAIL wrap_cnt16: got %0d expected 17", cnt[3]);
        end
        // clear wins over the simultaneous push, but the word still lands
        bus.valid_i = 1'b1; bus.sel_i = 2'd3; bus.data_i = 8'hC5; bus.clr_cnt_i = 1'b1;
        #1;
        vectors++;
        if (bus.ready_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL clr_ready: got %b expected 1", bus.ready_o);
        end
        tick();
        bus.clr_cnt_i = 1'b0;
        bus.valid_i   = 1'b0;
        vectors++;
        if (cnt4_3 !== 4'd0 || cnt[3] !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL clr_cnt: got c4=%0d c16=%0d expected 0 0", cnt4_3, cnt[3]);
        end
        vectors++;
        if (bus.valid_o[3] !== 1'b1 || dout[3] !== 8'hC5) begin
            miscompares++;
            $display("[TB] FAIL clr_deliver: got v=%b d3=%h expected v=1 d3=c5", bus.valid_o[3], dout[3]);
        end
        tick();
    endtask

    task automatic test_reset_midstream();
        bus.ready_i = 4'h0;
        for (int k = 0; k < 4; k++) begin
            bus.valid_i = 1'b1; bus.sel_i = 2'(k); bus.data_i = 8'hE0 + 8'(k);
            tick();
        end
        vectors++;
        if (bus.valid_o !== 4'hF) begin
            miscompares++;
            $display("[TB] FAIL mid_fill: got %b expected 1111", bus.valid_o);
        end
        bus.sel_i = 2'd1;
        #1;
        vectors++;
        if (bus.ready_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mid_stall_ready: got %b expected 0", bus.ready_o);
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.valid_o !== 4'b0000 || bus.data_o !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_out: got v=%b d=%h expected v=0000 d=0", bus.valid_o, bus.data_o);
        end
        vectors++;
        if (bus.cnt_o !== 64'h0 || bus4.cnt_o !== 16'h0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_cnt: got %h / %h expected 0 / 0", bus.cnt_o, bus4.cnt_o);
        end
        vectors++;
        if (bus.ready_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_ready: got %b expected 1", bus.ready_o);
        end
        bus.valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [7:0] q [4][$];
        int         cnt_model [4];
        logic [3:0] stall_prev;
        logic [7:0] hold_data [4];
        logic       exp_ready;

        for (int k = 0; k < 4; k++) begin
            cnt_model[k] = 0;
            hold_data[k] = '0;
        end
        stall_prev = '0;
        clear_counters();

        for (int c = 0; c < 10000; c++) begin
            bus.valid_i = 1'($urandom_range(0, 1));
            bus.sel_i   = 2'($urandom_range(0, 3));
            bus.data_i  = 8'($urandom);
            bus.ready_i = 4'($urandom);
            #1;
            exp_ready = (q[bus.sel_i].size() == 0) || bus.ready_i[bus.sel_i];
            vectors++;
            if (bus.ready_o !== exp_ready) begin
                miscompares++;
                $display("[TB] FAIL rnd_ready cyc%0d: got %b expected %b", c, bus.ready_o, exp_ready);
            end
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (bus.valid_o[k] !== (q[k].size() != 0)) begin
                    miscompares++;
                    $display("[TB] FAIL rnd_valid cyc%0d ch%0d: got %b expected %b",
                             c, k, bus.valid_o[k], q[k].size() != 0);
                end
                if (q[k].size() != 0) begin
                    vectors++;
                    if (dout[k] !== q[k][0]) begin
                        miscompares++;
                        $display("[TB] FAIL rnd_data cyc%0d ch%0d: got %h expected %h", c, k, dout[k], q[k][0]);
                    end
                end
                if (stall_prev[k]) begin
                    vectors++;
                    if (bus.valid_o[k] !== 1'b1 || dout[k] !== hold_data[k]) begin
                        miscompares++;
                        $display("[TB] FAIL rnd_stable cyc%0d ch%0d: got v=%b d=%h expected v=1 d=%h",
                                 c, k, bus.valid_o[k], dout[k], hold_data[k]);
                    end
                end
            end
            for (int k = 0; k < 4; k++) begin
                stall_prev[k] = (q[k].size() != 0) && !bus.ready_i[k];
                hold_data[k]  = dout[k];
                if (q[k].size() != 0 && bus.ready_i[k]) begin
                    void'(q[k].pop_front());
                end
            end
            if (bus.valid_i && exp_ready) begin
                q[bus.sel_i].push_back(bus.data_i);
                cnt_model[bus.sel_i]++;
            end
            tick();
        end

        bus.valid_i = 1'b0;
        bus.ready_i = 4'hF;
        tick();
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (cnt[k] !== 16'(cnt_model[k])) begin
                miscompares++;
                $display("[TB] FAIL rnd_cnt ch%0d: got %0d expected %0d", k, cnt[k], cnt_model[k]);
            end
        end
        vectors++;
        if (cnt4_3 !== 4'(cnt_model[3])) begin
            miscompares++;
            $display("[TB] FAIL rnd_cnt4: got %0d expected %0d", cnt4_3, 4'(cnt_model[3]));
        end
        vectors++;
        if (bus.valid_o !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL rnd_drain: got %b expected 0000", bus.valid_o);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        $display("[TB] reset checks done");
        test_basic_routing();
        test_backpressure();
        test_back_to_back();
        test_wrap_clear();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
